// File: rtl/bus_arbiter_2x1_pkg.sv
// Shared definitions for the two-requester bus arbiter: state encoding and
// default sizing constants.
package bus_arbiter_2x1_pkg;

    // Arbiter states: free arbitration, or grant held by requester 0 / 1.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_MAX_BURST = 4;
    localparam int CNT_W         = 4;

endpackage

// File: rtl/bus_arbiter_2x1_mux.sv
// 2:1 data mux cell: s=0 passes d0, s=1 passes d1.
module mux_2x1_32_bit #(
    parameter int W = 32
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         s,
    output logic [W-1:0] y
);

    // Pure combinational select.
    assign y = s ? d1 : d0;

endmodule

// File: rtl/bus_arbiter_2x1.sv
// Two-requester round-robin arbiter with optional bounded burst lock.
// Selected word is registered into a one-entry output buffer.
//
// Handshake: every port pair follows valid/ready -- a word moves when valid
// and ready are both high at a rising edge; valid never waits on ready, and
// a holder of valid keeps its word stable until it is taken.
module bus_arbiter_2x1
    import bus_arbiter_2x1_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_lock,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_lock,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel,
    output arb_state_t       dbg_state
);

    // Burst limit widened by one bit so the count+1 compare never overflows.
    localparam logic [CNT_W:0] BURST_LIM = (CNT_W+1)'(MAX_BURST);
    localparam bit             LOCK_EN   = (MAX_BURST > 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_sel;
    logic               w_sel;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_src;
    logic [WIDTH-1:0]   w_mux_data;
    logic               w_slot_free;
    logic               w_xfer;
    logic               w_lock_sel;
    logic [CNT_W:0]     w_cnt_inc;
    logic               w_cnt_hit;

    mux_2x1_32_bit #(
        .W (WIDTH)
    ) u_mux (
        .d0 (in0_data),
        .d1 (in1_data),
        .s  (w_sel),
        .y  (w_mux_data)
    );

    // Grant: locked owner wins; otherwise sole requester, or round-robin on a
    // tie; with no requester the previous grant is held. Forced to 0 in reset.
    always_comb begin
        w_sel = r_sel;
        if (reset) begin
            w_sel = 1'b0;
        end else begin
            case (r_state)
                LOCK0:   w_sel = 1'b0;
                LOCK1:   w_sel = 1'b1;
                default: begin
                    if (in0_valid && in1_valid) begin
                        w_sel = !r_last;
                    end else if (in0_valid) begin
                        w_sel = 1'b0;
                    end else if (in1_valid) begin
                        w_sel = 1'b1;
                    end
                end
            endcase
        end
    end

    // Only the granted requester sees ready, and only when the buffer can take a word.
    assign w_slot_free = !r_out_valid || out_ready;
    assign in0_ready   = !reset && !w_sel && w_slot_free;
    assign in1_ready   =  !reset && w_sel && w_slot_free;
    assign w_xfer      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
    assign w_lock_sel  = w_sel ? in1_lock : in0_lock;
    assign w_cnt_inc   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_cnt_hit   = (w_cnt_inc == BURST_LIM);

    // Next-state logic: enter lock from ARB, count locked beats, and release
    // on limit, unlocked beat, or abandoned lock.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ARB: begin
                if (w_xfer) begin
                    w_last_nxt = w_sel;
                    if (w_lock_sel && LOCK_EN) begin
                        w_state_nxt = w_sel ? LOCK1 : LOCK0;
                        w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            LOCK0, LOCK1: begin
                if (w_xfer && w_lock_sel) begin
                    if (w_cnt_hit) begin
                        w_state_nxt = ARB;
                        w_cnt_nxt   = '0;
                        w_last_nxt  = w_sel;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else if (w_xfer || !w_lock_sel) begin
                    w_state_nxt = ARB;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = w_sel;
                end
            end
            default: begin
                w_state_nxt = ARB;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Arbiter state registers; last=1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel;
        end
    end

    // One-entry output buffer: load on transfer, empty when consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_src   <= w_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign sel       = w_sel;
    assign dbg_state = r_state;

endmodule
